fp8_arbiter: RTL and testbench

//  Shares one fp8 arithmetic unit among N_REQ requesters. Arbitration is round-robin.

---
 rtl/fp8_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fp8_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp8_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp8_arbiter
// Brief    : Round-robin sharing of one fixed-latency fp8 unit among N_REQ
//            requesters, with a tag pipeline that routes results back.
// Revision : 1.0 - initial release
// ============================================================================
module fp8_arbiter #(
  parameter int N_REQ  = 4,
  parameter int FP_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               flush_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ*8-1:0] req_a_i,
  input  logic [N_REQ*8-1:0] req_b_i,
  input  logic [N_REQ*2-1:0] req_op_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [7:0]         fp_a_o,
  output logic [7:0]         fp_b_o,
  output logic [1:0]         fp_op_o,
  input  logic [7:0]         fp_result_i,
  input  logic [4:0]         fp_flags_i,
  output logic [N_REQ-1:0]   rsp_valid_o,
  output logic [7:0]         rsp_result_o,
  output logic [4:0]         rsp_flags_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   issue_count_o
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  grant_id;
  logic             grant_found;
  logic             issue;

  logic [FP_LAT-1:0] vld_q;
  logic [ID_W-1:0]   id_q [FP_LAT];

  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_result_q;
  logic [4:0]       rsp_flags_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // First valid requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    int        idx;
    logic [ID_W-1:0] idx_id;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    idx_id      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx    = (int'(ptr_q) + k) % N_REQ;
      idx_id = ID_W'(idx);
      if (!grant_found && req_valid_i[idx_id]) begin
        grant_found = 1'b1;
        grant_id    = idx_id;
      end
    end
  end

  assign issue = grant_found && reset_ni && !flush_i;

  always_comb begin
    req_ready_o = '0;
    fp_a_o      = '0;
    fp_b_o      = '0;
    fp_op_o     = '0;
    if (issue) begin
      req_ready_o = N_REQ'(1) << grant_id;
      fp_a_o      = req_a_i[{grant_id, 3'b000} +: 8];
      fp_b_o      = req_b_i[{grant_id, 3'b000} +: 8];
      fp_op_o     = req_op_i[{grant_id, 1'b0} +: 2];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Tag valid bits are cleared by reset or flush; ids are don't-care when invalid.
  always_ff @(posedge clk_i) begin
    if (!reset_ni || flush_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= issue;
      for (int k = 1; k < FP_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    id_q[0] <= grant_id;
    for (int k = 1; k < FP_LAT; k++) begin
      id_q[k] <= id_q[k-1];
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    if (vld_q[FP_LAT-1]) begin
      rsp_valid_d = N_REQ'(1) << id_q[FP_LAT-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else if (flush_i) begin
      rsp_valid_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (vld_q[FP_LAT-1]) begin
        rsp_result_q <= fp_result_i;
        rsp_flags_q  <= fp_flags_i;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (issue && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_result_o  = rsp_result_q;
  assign rsp_flags_o   = rsp_flags_q;
  assign busy_o        = |vld_q;
  assign issue_count_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fp8_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp8_arbiter
// Brief    : Self-checking bench for fp8_arbiter with a stand-in fp8 unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp8_arbiter;

  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic [N-1:0]  req_valid;
  logic [N*8-1:0] req_a, req_b;
  logic [N*2-1:0] req_op;
  logic [N-1:0]  req_ready;
  logic [7:0]    fp_a, fp_b;
  logic [1:0]    fp_op;
  logic [7:0]    fp_result;
  logic [4:0]    fp_flags;
  logic [N-1:0]  rsp_valid;
  logic [7:0]    rsp_result;
  logic [4:0]    rsp_flags;
  logic          busy;
  logic [CW-1:0] issue_count;

  always #5 clk = ~clk;

  fp8_arbiter #(.N_REQ(N), .FP_LAT(LAT), .CNT_W(CW)) dut (
    .clk_i(clk), .reset_ni(reset_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
    .req_ready_o(req_ready), .fp_a_o(fp_a), .fp_b_o(fp_b), .fp_op_o(fp_op),
    .fp_result_i(fp_result), .fp_flags_i(fp_flags),
    .rsp_valid_o(rsp_valid), .rsp_result_o(rsp_result), .rsp_flags_o(rsp_flags),
    .busy_o(busy), .issue_count_o(issue_count)
  );

  // Stand-in arithmetic unit: {flags, result}, op 0 is an integer sum.
  function automatic logic [12:0] fp_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op);
    logic [8:0] r;
    case (op)
      2'd0:    r = {1'b0, a} + {1'b0, b};
      2'd1:    r = {1'b0, a} - {1'b0, b};
      2'd2:    r = {1'b0, a & b};
      default: r = {1'b0, a ^ b};
    endcase
    return {r[8], (r[7:0] == 8'h00), a[7] ^ b[7], op, r[7:0]};
  endfunction

  logic [12:0] fp_pipe [LAT];
  always @(posedge clk) begin
    fp_pipe[0] <= fp_model(fp_a, fp_b, fp_op);
    for (int k = 1; k < LAT; k++) fp_pipe[k] <= fp_pipe[k-1];
  end
  assign {fp_flags, fp_result} = fp_pipe[LAT-1];

  typedef struct {
    int          due;
    int          id;
    logic [12:0] val;
  } pend_t;

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] exp_ready;
  } vec_t;

  pend_t       pend[$];
  int          m_ptr, m_cnt, m_cycle;
  logic [7:0]  m_res;
  logic [4:0]  m_flg;
  int          n_checks, n_errors, n_rsp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cycle);
    end
  endtask

  // One clock: check the combinational grant, advance the model, check registered outputs.
  task automatic step(input bit use_tbl, input logic [N-1:0] tbl_ready);
    int           g;
    logic [N-1:0] exp_ready, exp_rv;
    logic [7:0]   ea, eb;
    logic [1:0]   eo;
    @(negedge clk);
    g = -1;
    if (reset_n && !flush) begin
      for (int k = 0; k < N; k++) begin
        int i = (m_ptr + k) % N;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    exp_ready = '0; ea = '0; eb = '0; eo = '0;
    if (g >= 0) begin
      exp_ready = N'(1 << g);
      ea = req_a[g*8 +: 8];
      eb = req_b[g*8 +: 8];
      eo = req_op[g*2 +: 2];
    end
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (use_tbl) chk("tbl_ready", 32'(req_ready), 32'(tbl_ready));
    chk("fp_a", 32'(fp_a), 32'(ea));
    chk("fp_b", 32'(fp_b), 32'(eb));
    chk("fp_op", 32'(fp_op), 32'(eo));
    @(posedge clk);
    m_cycle++;
    exp_rv = '0;
    if (!reset_n) begin
      m_ptr = 0; m_cnt = 0; m_res = '0; m_flg = '0;
      pend.delete();
    end else if (flush) begin
      pend.delete();
    end else begin
      if (pend.size() > 0 && pend[0].due == m_cycle) begin
        exp_rv = N'(1 << pend[0].id);
        m_res  = pend[0].val[7:0];
        m_flg  = pend[0].val[12:8];
        void'(pend.pop_front());
      end
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        pend.push_back('{due: m_cycle + LAT, id: g, val: fp_model(ea, eb, eo)});
      end
    end
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("rsp_result", 32'(rsp_result), 32'(m_res));
    chk("rsp_flags", 32'(rsp_flags), 32'(m_flg));
    chk("busy", 32'(busy), 32'(pend.size() != 0));
    chk("issue_count", 32'(issue_count), 32'(m_cnt));
    if (rsp_valid != '0) n_rsp++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic rand_ops();
    req_a  = $urandom;
    req_b  = $urandom;
    req_op = 8'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vec [12];
    int   base;
    vec[0]  = '{4'b0000, 4'b0000};
    vec[1]  = '{4'b0100, 4'b0100};
    vec[2]  = '{4'b1010, 4'b1000};
    vec[3]  = '{4'b1010, 4'b0010};
    vec[4]  = '{4'b0011, 4'b0001};
    vec[5]  = '{4'b1111, 4'b0010};
    vec[6]  = '{4'b1111, 4'b0100};
    vec[7]  = '{4'b1111, 4'b1000};
    vec[8]  = '{4'b0001, 4'b0001};
    vec[9]  = '{4'b0001, 4'b0001};
    vec[10] = '{4'b1000, 4'b1000};
    vec[11] = '{4'b1100, 4'b0100};

    n_checks = 0; n_errors = 0; n_rsp = 0;
    m_ptr = 0; m_cnt = 0; m_cycle = 0; m_res = '0; m_flg = '0;
    reset_n = 1'b0; flush = 1'b0; req_valid = '0;
    rand_ops();

    // Reset held with every requester asking.
    req_valid = 4'hF;
    run(2);
    chk("reset_count", 32'(issue_count), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);

    // Single requester 2.
    reset_n = 1'b1;
    req_valid = 4'b0100;
    req_a[16 +: 8] = 8'h38; req_b[16 +: 8] = 8'h40; req_op[4 +: 2] = 2'b00;
    step(1'b1, 4'b0100);
    req_valid = '0;
    run(LAT);
    chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("single_rsp_result", 32'(rsp_result), 32'h78);
    run(1);

    // Round-robin from reset, all requesters held.
    reset_n = 1'b0; run(1); reset_n = 1'b1;
    base = n_rsp;
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      step(1'b1, N'(1 << (k % N)));
    end
    req_valid = '0;
    run(LAT + 1);
    chk("rr_count", 32'(issue_count), 32'd8);
    chk("rr_rsp_total", 32'(n_rsp - base), 32'd8);

    // Wrap: pointer at 3 with requesters 1 and 3 valid.
    req_valid = 4'b0100; step(1'b1, 4'b0100);
    req_valid = 4'b1010; step(1'b1, 4'b1000);
    step(1'b1, 4'b0010);
    req_valid = '0; run(LAT + 1);

    // Table of arbitration vectors starting from pointer 0.
    reset_n = 1'b0; run(1); reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rand_ops();
      req_valid = vec[i].valid;
      step(1'b1, vec[i].exp_ready);
    end
    req_valid = '0; run(LAT + 1);

    // Flush one cycle after two issues; flush beats a full request set.
    base = n_rsp;
    req_valid = 4'b0001; step(1'b1, 4'b0001);
    req_valid = 4'b0010; step(1'b1, 4'b0010);
    req_valid = 4'hF; flush = 1'b1; step(1'b1, 4'b0000);
    chk("flush_busy", 32'(busy), 32'd0);
    flush = 1'b0; req_valid = '0; run(LAT + 1);
    chk("flush_dropped", 32'(n_rsp - base), 32'd0);
    req_valid = 4'b0100; step(1'b0, '0);
    req_valid = '0; run(LAT);
    chk("post_flush_rsp", 32'(rsp_valid), 32'h4);
    run(1);

    // Same with reset instead of flush.
    base = n_rsp;
    req_valid = 4'b0001; step(1'b0, '0);
    req_valid = 4'b0010; step(1'b0, '0);
    reset_n = 1'b0; req_valid = '0; step(1'b1, 4'b0000);
    chk("reset_mid_count", 32'(issue_count), 32'd0);
    chk("reset_mid_busy", 32'(busy), 32'd0);
    reset_n = 1'b1; run(LAT + 1);
    chk("reset_dropped", 32'(n_rsp - base), 32'd0);

    // Saturation of the issue counter.
    base = n_rsp;
    req_valid = 4'hF;
    for (int k = 0; k < 20; k++) begin
      rand_ops();
      step(1'b0, '0);
    end
    req_valid = '0; run(LAT + 1);
    chk("sat_count", 32'(issue_count), 32'hF);
    chk("sat_rsp_total", 32'(n_rsp - base), 32'd20);

    // Randomized traffic with occasional flush and reset.
    for (int k = 0; k < 400; k++) begin
      rand_ops();
      req_valid = N'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      reset_n   = ($urandom_range(0, 49) != 0);
      step(1'b0, '0);
    end
    flush = 1'b0; reset_n = 1'b1; req_valid = '0;
    run(LAT + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
